// File: rtl/ip_codma_pkg.sv
// ----------------------------------------------------------------------------
// ip_codma_pkg
// Shared CoDMA definitions used by the CRC engine:
//   - crc_state_t        : CRC engine FSM states
//   - CODMA_CRC_*        : default CRC-32/MPEG-2 parameters and block size
//   - crc32_byte_step()  : one byte of MSB-first, non-reflected CRC-32
// ----------------------------------------------------------------------------
package ip_codma_pkg;

    typedef enum logic [1:0] {
        CRC_IDLE = 2'd0,
        CRC_RUN  = 2'd1,
        CRC_DONE = 2'd2
    } crc_state_t;

    localparam logic [31:0] CODMA_CRC_POLY      = 32'h04C1_1DB7;
    localparam logic [31:0] CODMA_CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CODMA_CRC_XOROUT    = 32'h0000_0000;
    // 8 words x 4 bytes per block
    localparam int unsigned CODMA_CRC_MAX_BYTES = 32;

    // The byte enters the top of the register in one XOR, then eight
    // shift/conditional-XOR iterations; equivalent to feeding its bits
    // MSB-first one at a time.
    function automatic logic [31:0] crc32_byte_step(
        input logic [31:0] crc,
        input logic [7:0]  data_byte,
        input logic [31:0] poly
    );
        logic [31:0] c;
        c = crc ^ {data_byte, 24'h0};
        for (int i = 0; i < 8; i++) begin
            if (c[31]) begin
                c = {c[30:0], 1'b0} ^ poly;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/ip_codma_crc_engine.sv
// ----------------------------------------------------------------------------
// ip_codma_crc_engine
// Downstream compute stage of the CoDMA main controller. Computes a CRC-32
// over a latched block of up to MAX_BYTES bytes, one byte per clock, and
// returns a one-cycle completion pulse. CRC state is carried across blocks
// unless first_i reloads INIT, allowing multi-block messages.
//
// Ports:
//   clk_i           clock
//   reset_n_i       asynchronous active-low reset
//   start_i         one-cycle request; block inputs sampled this cycle
//   stop_i          abort to idle, no completion pulse; wins over start_i
//   data_i          block data, word 0 first, bytes [31:24]..[7:0] per word
//   len_i           valid bytes in block (0..32, larger values saturate)
//   first_i         reload INIT before this block
//   last_i          block ends the message
//   expected_crc_i  reference CRC for the compare option
//   busy_o          engine not idle
//   crc_flag_o      one-cycle pulse: block processed
//   crc_o           crc ^ XOROUT, valid with crc_flag_o, held afterwards
//   crc_last_o      latched last_i, valid with crc_flag_o
//   crc_match_o     compare result, valid with crc_flag_o
//
// Build option:
//   CODMA_CRC_COMPARE_EN  when defined, crc_match_o reports
//                         (crc ^ XOROUT) == expected_crc_i on the last block;
//                         otherwise crc_match_o is tied low.
// ----------------------------------------------------------------------------
module ip_codma_crc_engine
    import ip_codma_pkg::*;
#(
    parameter logic [31:0] POLY      = CODMA_CRC_POLY,
    parameter logic [31:0] INIT      = CODMA_CRC_INIT,
    parameter logic [31:0] XOROUT    = CODMA_CRC_XOROUT,
    parameter int unsigned MAX_BYTES = CODMA_CRC_MAX_BYTES
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [7:0][31:0] data_i,
    input  logic [5:0]       len_i,
    input  logic             first_i,
    input  logic             last_i,
    input  logic [31:0]      expected_crc_i,
    output logic             busy_o,
    output logic             crc_flag_o,
    output logic [31:0]      crc_o,
    output logic             crc_last_o,
    output logic             crc_match_o
);

    localparam logic [5:0] LP_MAX_LEN = 6'(MAX_BYTES);

    // ------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------
    crc_state_t       r_state, w_state_nxt;
    logic [31:0]      r_crc, w_crc_nxt;
    logic [5:0]       r_cnt, w_cnt_nxt;
    logic [5:0]       r_len, w_len_nxt;
    logic             r_last, w_last_nxt;
    logic [7:0][31:0] r_data, w_data_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_flag, w_flag_nxt;
    logic [31:0]      r_out, w_out_nxt;
    logic             r_last_out, w_last_out_nxt;

    // Values presented on the cycle the FSM heads into CRC_DONE
    logic             w_done;
    logic [31:0]      w_done_crc;
    logic             w_done_last;

    logic [5:0]       w_len_sat;
    logic [31:0]      w_word;
    logic [7:0]       w_byte;
    logic [31:0]      w_step;

`ifdef CODMA_CRC_COMPARE_EN
    logic [31:0]      r_exp, w_exp_nxt;
    logic             r_match, w_match_nxt;
    logic [31:0]      w_done_exp;
`else
    logic             w_unused_exp;
    assign w_unused_exp = ^expected_crc_i;
`endif

    assign w_len_sat = (len_i > LP_MAX_LEN) ? LP_MAX_LEN : len_i;

    // Byte k lives in word k/4; within a word the high byte goes first
    assign w_word = r_data[r_cnt[4:2]];

    always_comb begin
        w_byte = w_word[31:24];
        case (r_cnt[1:0])
            2'd0:    w_byte = w_word[31:24];
            2'd1:    w_byte = w_word[23:16];
            2'd2:    w_byte = w_word[15:8];
            default: w_byte = w_word[7:0];
        endcase
    end

    assign w_step = crc32_byte_step(r_crc, w_byte, POLY);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_crc_nxt      = r_crc;
        w_cnt_nxt      = r_cnt;
        w_len_nxt      = r_len;
        w_last_nxt     = r_last;
        w_data_nxt     = r_data;
        w_busy_nxt     = r_busy;
        w_flag_nxt     = 1'b0;
        w_out_nxt      = r_out;
        w_last_out_nxt = 1'b0;
        w_done         = 1'b0;
        w_done_crc     = r_crc;
        w_done_last    = r_last;
`ifdef CODMA_CRC_COMPARE_EN
        w_exp_nxt      = r_exp;
        w_match_nxt    = 1'b0;
        w_done_exp     = r_exp;
`endif

        unique case (r_state)
            CRC_IDLE: begin
                if (start_i) begin
                    w_data_nxt = data_i;
                    w_len_nxt  = w_len_sat;
                    w_last_nxt = last_i;
                    w_crc_nxt  = first_i ? INIT : r_crc;
                    w_cnt_nxt  = '0;
                    w_busy_nxt = 1'b1;
`ifdef CODMA_CRC_COMPARE_EN
                    w_exp_nxt  = expected_crc_i;
`endif
                    if (w_len_sat != 6'd0) begin
                        w_state_nxt = CRC_RUN;
                    end else begin
                        // Empty block: straight to done with the register
                        // as loaded, so the result uses the live inputs.
                        w_state_nxt = CRC_DONE;
                        w_done      = 1'b1;
                        w_done_crc  = first_i ? INIT : r_crc;
                        w_done_last = last_i;
`ifdef CODMA_CRC_COMPARE_EN
                        w_done_exp  = expected_crc_i;
`endif
                    end
                end
            end
            CRC_RUN: begin
                w_crc_nxt = w_step;
                w_cnt_nxt = r_cnt + 6'd1;
                if (r_cnt == (r_len - 6'd1)) begin
                    w_state_nxt = CRC_DONE;
                    w_done      = 1'b1;
                    w_done_crc  = w_step;
                end
            end
            CRC_DONE: begin
                w_state_nxt = CRC_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = CRC_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // Flag and result are registered on the way into CRC_DONE so they
        // are visible exactly during the CRC_DONE cycle.
        if (w_done) begin
            w_flag_nxt     = 1'b1;
            w_out_nxt      = w_done_crc ^ XOROUT;
            w_last_out_nxt = w_done_last;
`ifdef CODMA_CRC_COMPARE_EN
            w_match_nxt    = w_done_last && ((w_done_crc ^ XOROUT) == w_done_exp);
`endif
        end

        if (stop_i) begin
            w_state_nxt    = CRC_IDLE;
            w_crc_nxt      = INIT;
            w_cnt_nxt      = '0;
            w_busy_nxt     = 1'b0;
            w_flag_nxt     = 1'b0;
            w_out_nxt      = r_out;
            w_last_out_nxt = 1'b0;
`ifdef CODMA_CRC_COMPARE_EN
            w_match_nxt    = 1'b0;
`endif
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= CRC_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_crc      <= INIT;
            r_cnt      <= '0;
            r_len      <= '0;
            r_last     <= 1'b0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_flag     <= 1'b0;
            r_out      <= '0;
            r_last_out <= 1'b0;
        end else begin
            r_crc      <= w_crc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_len      <= w_len_nxt;
            r_last     <= w_last_nxt;
            r_data     <= w_data_nxt;
            r_busy     <= w_busy_nxt;
            r_flag     <= w_flag_nxt;
            r_out      <= w_out_nxt;
            r_last_out <= w_last_out_nxt;
        end
    end

`ifdef CODMA_CRC_COMPARE_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_exp   <= '0;
            r_match <= 1'b0;
        end else begin
            r_exp   <= w_exp_nxt;
            r_match <= w_match_nxt;
        end
    end

    assign crc_match_o = r_match;
`else
    assign crc_match_o = 1'b0;
`endif

    assign busy_o     = r_busy;
    assign crc_flag_o = r_flag;
    assign crc_o      = r_out;
    assign crc_last_o = r_last_out;

endmodule

// File: tb/tb_ip_codma_crc_engine.sv
// ----------------------------------------------------------------------------
// tb_ip_codma_crc_engine
// Scoreboard bench for ip_codma_crc_engine. The driver pushes the expected
// completion (crc, last, match, cycle) when it issues a block; a monitor pops
// and compares whenever crc_flag_o is seen. Expected CRCs come from a
// bit-serial CRC-32/MPEG-2 model over the block's byte stream.
// ----------------------------------------------------------------------------
module tb_ip_codma_crc_engine;

    localparam logic [31:0] POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] XOROUT = 32'h0000_0000;
    localparam logic [31:0] CHECK  = 32'h0376_E6E7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic [7:0][31:0] data;
    logic [5:0]       len;
    logic             first;
    logic             last;
    logic [31:0]      exp_crc;
    logic             busy_o;
    logic             crc_flag_o;
    logic [31:0]      crc_o;
    logic             crc_last_o;
    logic             crc_match_o;

    always #5 clk = ~clk;

    ip_codma_crc_engine dut (
        .clk_i          (clk),
        .reset_n_i      (rst_n),
        .start_i        (start),
        .stop_i         (stop),
        .data_i         (data),
        .len_i          (len),
        .first_i        (first),
        .last_i         (last),
        .expected_crc_i (exp_crc),
        .busy_o         (busy_o),
        .crc_flag_o     (crc_flag_o),
        .crc_o          (crc_o),
        .crc_last_o     (crc_last_o),
        .crc_match_o    (crc_match_o)
    );

    typedef struct {
        logic [31:0] crc;
        logic        last;
        logic        match;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] m_crc  = 32'hFFFF_FFFF;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Bit-serial reference: message bits MSB-first, word 0 first
    function automatic logic [31:0] model_block(input logic [31:0] c0,
                                                input logic [7:0][31:0] d, input int l);
        logic [31:0] c;
        logic [31:0] w;
        logic [7:0]  b;
        logic        fb;
        int          n;
        c = c0;
        n = (l > 32) ? 32 : l;
        for (int k = 0; k < n; k++) begin
            w = d[k / 4];
            b = 8'(w >> (24 - 8 * (k % 4)));
            for (int i = 7; i >= 0; i--) begin
                fb = c[31] ^ b[i];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ POLY;
            end
        end
        return c;
    endfunction

    // Monitor: every flag must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1 && crc_flag_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_flag: got crc_flag_o=1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("crc_o", crc_o, mon_e.crc);
                chk("crc_last_o", {31'b0, crc_last_o}, {31'b0, mon_e.last});
                chk("crc_match_o", {31'b0, crc_match_o}, {31'b0, mon_e.match});
                chk("flag_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    // Issue one block; returns at the negedge of cycle 1
    task automatic issue(input logic [7:0][31:0] d, input int l, input logic f,
                         input logic la, input logic [31:0] ex, input logic push,
                         input logic use_ref, input logic [31:0] ref_crc, output int n);
        logic [31:0] base;
        logic [31:0] newc;
        logic [31:0] outv;
        exp_t        e;
        @(negedge clk);
        start   = 1'b1;
        data    = d;
        len     = l[5:0];
        first   = f;
        last    = la;
        exp_crc = ex;
        n       = (l > 32) ? 32 : l;
        base    = f ? INIT : m_crc;
        newc    = model_block(base, d, l);
        outv    = use_ref ? ref_crc : (newc ^ XOROUT);
        if (push) begin
            m_crc   = newc;
            e.crc   = outv;
            e.last  = la;
`ifdef CODMA_CRC_COMPARE_EN
            e.match = la && (outv == ex);
`else
            e.match = 1'b0;
`endif
            e.cyc   = cyc + n + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Checks busy_o window from cycle 'from_c' through n+2, then that the
    // expected flag was consumed within that bound.
    task automatic wait_block(input int n, input int from_c);
        for (int c = from_c; c <= n + 2; c++) begin
            if (c > from_c) @(negedge clk);
            chk("busy_o", {31'b0, busy_o}, {31'b0, (c <= n + 1)});
        end
        chk("pending_flags", 32'(sb.size()), 32'd0);
    endtask

    task automatic run_block(input logic [7:0][31:0] d, input int l, input logic f,
                             input logic la, input logic [31:0] ex,
                             input logic use_ref, input logic [31:0] ref_crc);
        int n;
        issue(d, l, f, la, ex, 1'b1, use_ref, ref_crc, n);
        wait_block(n, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0][31:0] d_chk;
        logic [7:0][31:0] d_a;
        logic [7:0][31:0] d_b;
        logic [7:0][31:0] d_r;
        logic [31:0]      pred;
        int               n;
        int               l;
        logic             f;
        logic             la;

        d_chk    = '0;
        d_chk[0] = 32'h3132_3334;
        d_chk[1] = 32'h3536_3738;
        d_chk[2] = 32'h3900_0000;
        d_a      = '0;
        d_a[0]   = 32'h3132_3334;
        d_b      = '0;
        d_b[0]   = 32'h3536_3738;
        d_b[1]   = 32'h3900_0000;

        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        data    = '0;
        len     = '0;
        first   = 1'b0;
        last    = 1'b0;
        exp_crc = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, busy_o}, 32'd0);
        chk("reset_flag", {31'b0, crc_flag_o}, 32'd0);
        chk("reset_crc", crc_o, 32'd0);
        chk("reset_last", {31'b0, crc_last_o}, 32'd0);
        chk("reset_match", {31'b0, crc_match_o}, 32'd0);
        rst_n = 1'b1;
        m_crc = INIT;
        repeat (2) @(negedge clk);

        // Check value, matching and non-matching expected CRC
        run_block(d_chk, 9, 1'b1, 1'b1, CHECK, 1'b1, CHECK);
        run_block(d_chk, 9, 1'b1, 1'b1, 32'h0376_E6E6, 1'b1, CHECK);

        // Two-block accumulation of the same message
        run_block(d_a, 4, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        run_block(d_b, 5, 1'b0, 1'b1, CHECK, 1'b1, CHECK);

        // Empty block and oversize length
        run_block(d_chk, 0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
        for (int w = 0; w < 8; w++) d_r[w] = $urandom;
        run_block(d_r, 40, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0);

        // Start during a run is ignored
        for (int w = 0; w < 8; w++) d_r[w] = $urandom;
        issue(d_r, 12, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, n);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        data  = ~d_r;
        len   = 6'd5;
        first = 1'b0;
        last  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_block(n, 4);

        // Abort at cycle 5 of a 32-byte run
        for (int w = 0; w < 8; w++) d_r[w] = $urandom;
        issue(d_r, 32, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, n);
        repeat (4) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("busy_after_stop", {31'b0, busy_o}, 32'd0);
        m_crc = INIT;
        repeat (40) @(negedge clk);
        run_block(d_chk, 9, 1'b0, 1'b1, CHECK, 1'b1, CHECK);
        run_block(d_chk, 9, 1'b1, 1'b1, CHECK, 1'b1, CHECK);

        // Asynchronous reset mid-run
        for (int w = 0; w < 8; w++) d_r[w] = $urandom;
        issue(d_r, 32, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, n);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_busy", {31'b0, busy_o}, 32'd0);
        chk("async_reset_flag", {31'b0, crc_flag_o}, 32'd0);
        chk("async_reset_crc", crc_o, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        m_crc = INIT;
        repeat (40) @(negedge clk);
        run_block(d_chk, 9, 1'b0, 1'b1, CHECK, 1'b1, CHECK);

        // Randomized multi-block traffic
        for (int t = 0; t < 24; t++) begin
            for (int w = 0; w < 8; w++) d_r[w] = $urandom;
            l    = int'($urandom_range(0, 40));
            f    = ($urandom_range(0, 3) == 0);
            la   = $urandom_range(0, 1) == 1;
            pred = model_block(f ? INIT : m_crc, d_r, l) ^ XOROUT;
            if ($urandom_range(0, 1) == 1) pred = pred ^ 32'h1;
            run_block(d_r, l, f, la, pred, 1'b0, 32'h0);
        end

        repeat (3) @(negedge clk);
        chk("final_pending", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
